// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: decoder/bus signals shared between the CPU core and the interrupt sequencer
interface interrupt_sequencer_if;
  logic clk_enable;
  logic irq;
  logic nmi;
  logic i_flag;
  logic boundary;
  logic [15:0] pc;
  logic [7:0] sp;
  logic [7:0] status;
  logic [7:0] data_in;
  logic int_pending;
  logic busy;
  logic [15:0] address;
  logic [7:0] data_out;
  logic rw;
  logic sp_dec;
  logic set_i;
  logic pc_load;
  logic [15:0] pc_value;
  modport master (
    input  clk_enable, irq, nmi, i_flag, boundary, pc, sp, status, data_in,
    output int_pending, busy, address, data_out, rw, sp_dec, set_i, pc_load, pc_value
  );
  modport slave (
    output clk_enable, irq, nmi, i_flag, boundary, pc, sp, status, data_in,
    input  int_pending, busy, address, data_out, rw, sp_dec, set_i, pc_load, pc_value
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: pushes PC and status, fetches the NMI/IRQ vector and reloads the PC
module interrupt_sequencer #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] NMI_VECTOR = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR = 16'hFFFE
) (
  input logic clk,
  input logic rst,
  interrupt_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD_PC} state_t;
  state_t state, next;
  logic en, start, nmi_q, armed, nmi_latch, nmi_rise, nmi_sel;
  logic [15:0] pc_cap, vector;
  logic [7:0] sp_cap, status_cap, lo, hi;
  assign en = bus.clk_enable;
  assign nmi_rise = armed & bus.nmi & ~nmi_q;
  assign bus.int_pending = nmi_latch | (bus.irq & ~bus.i_flag);
  assign bus.busy = state != IDLE;
  assign vector = nmi_sel ? NMI_VECTOR : IRQ_VECTOR;
  // NMI edge detection runs every edge; the first sample after reset only primes the history
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      nmi_q <= 1'b0;
      armed <= 1'b0;
      nmi_latch <= 1'b0;
    end else begin
      nmi_q <= bus.nmi;
      armed <= 1'b1;
      nmi_latch <= (nmi_latch & ~start) | nmi_rise;
    end
  // sequencer state plus context captured at start and vector bytes captured during the fetch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc_cap <= 16'h0;
      sp_cap <= 8'h0;
      status_cap <= 8'h0;
      nmi_sel <= 1'b0;
      lo <= 8'h0;
      hi <= 8'h0;
    end else if (en) begin
      state <= next;
      if (start) begin
        pc_cap <= bus.pc;
        sp_cap <= bus.sp;
        status_cap <= bus.status;
        nmi_sel <= nmi_latch;
      end
      if (state == VEC_LO) lo <= bus.data_in;
      if (state == VEC_HI) hi <= bus.data_in;
    end
  // next-state and bus outputs; pulses are gated by clk_enable so each fires once per state
  always_comb begin
    next = state;
    start = 1'b0;
    bus.address = 16'h0;
    bus.data_out = 8'h0;
    bus.rw = 1'b1;
    bus.sp_dec = 1'b0;
    bus.set_i = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_value = 16'h0;
    case (state)
      IDLE: if (bus.boundary && bus.int_pending) begin
        next = PUSH_PCH;
        start = en;
      end
      PUSH_PCH: begin
        next = PUSH_PCL;
        bus.address = {STACK_PAGE, sp_cap};
        bus.data_out = pc_cap[15:8];
        bus.rw = 1'b0;
        bus.sp_dec = en;
      end
      PUSH_PCL: begin
        next = PUSH_P;
        bus.address = {STACK_PAGE, sp_cap - 8'd1};
        bus.data_out = pc_cap[7:0];
        bus.rw = 1'b0;
        bus.sp_dec = en;
      end
      PUSH_P: begin
        next = VEC_LO;
        bus.address = {STACK_PAGE, sp_cap - 8'd2};
        bus.data_out = {status_cap[7:6], 2'b10, status_cap[3:0]};
        bus.rw = 1'b0;
        bus.sp_dec = en;
      end
      VEC_LO: begin
        next = VEC_HI;
        bus.address = vector;
      end
      VEC_HI: begin
        next = LOAD_PC;
        bus.address = vector + 16'd1;
      end
      LOAD_PC: begin
        next = IDLE;
        bus.pc_load = en;
        bus.set_i = en;
        bus.pc_value = {hi, lo};
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed and random stimulus against a step-table model of the interrupt sequence
module tb_interrupt_sequencer;
  logic clk = 1'b0;
  logic rst;
  interrupt_sequencer_if bus();
  interrupt_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] mem [0:65535];
  assign bus.data_in = bus.rw ? mem[bus.address] : 8'h00;
  int total = 0, passed = 0;
  logic [23:0] wlog [$];
  logic [15:0] llog [$];
  bit m_active = 0, m_sel = 0, m_latch = 0, m_prev = 0, m_armed = 0;
  int m_step = 0;
  logic [15:0] m_pc = 16'h0;
  logic [7:0] m_sp = 8'h0, m_st = 8'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // model: an interrupt sequence is six enabled steps taken from a fixed table
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_step = 0; m_latch = 0; m_prev = 0; m_armed = 0; m_sel = 0;
    end else begin
      bit rise, pend, st;
      rise = m_armed && bus.nmi && !m_prev;
      pend = m_latch || (bus.irq && !bus.i_flag);
      st = 0;
      if (bus.clk_enable) begin
        if (!m_active) begin
          if (bus.boundary && pend) begin
            st = 1; m_active = 1; m_step = 0;
            m_pc = bus.pc; m_sp = bus.sp; m_st = bus.status; m_sel = m_latch;
          end
        end else if (m_step == 5) m_active = 0;
        else m_step++;
      end
      m_latch = (m_latch && !(st && m_sel)) || rise;
      m_prev = bus.nmi;
      m_armed = 1;
    end
  end

  task automatic compare;
    logic [15:0] ea, epv, vec;
    logic [7:0] ed, off;
    logic erw, edec, eload, epend;
    vec = m_sel ? 16'hFFFA : 16'hFFFE;
    epend = m_latch || (bus.irq && !bus.i_flag);
    ea = 16'h0; ed = 8'h0; erw = 1; edec = 0; eload = 0; epv = 16'h0;
    if (m_active) begin
      off = m_sp - 8'(m_step);
      if (m_step < 3) begin
        ea = {8'h01, off};
        ed = m_step == 0 ? m_pc[15:8] : m_step == 1 ? m_pc[7:0] : ((m_st | 8'h20) & ~8'h10);
        erw = 0;
        edec = bus.clk_enable;
      end else if (m_step == 3) ea = vec;
      else if (m_step == 4) ea = vec + 16'd1;
      else begin
        eload = bus.clk_enable;
        epv = {mem[vec + 16'd1], mem[vec]};
      end
    end
    chk("cycle", 64'({bus.busy, bus.int_pending, bus.address, bus.data_out, bus.rw, bus.sp_dec, bus.set_i, bus.pc_load, bus.pc_value}),
                 64'({m_active, epend, ea, ed, erw, edec, eload, eload, epv}));
    if (bus.sp_dec) wlog.push_back({bus.address, bus.data_out});
    if (bus.pc_load) llog.push_back(bus.pc_value);
  endtask

  always @(posedge clk) begin
    #1;
    compare();
  end

  task automatic wait_busy(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.busy;
    end
  endtask

  task automatic wait_load(input int n0, output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = llog.size() > n0;
    end
  endtask

  task automatic start_irq(input logic [15:0] p, input logic [7:0] s, input logic [7:0] stat);
    @(negedge clk);
    bus.pc = p; bus.sp = s; bus.status = stat;
    bus.irq = 1; bus.i_flag = 0; bus.boundary = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n0, w0, ens;
    rst = 1;
    bus.clk_enable = 1; bus.irq = 0; bus.nmi = 0; bus.i_flag = 0; bus.boundary = 0;
    bus.pc = 16'h0; bus.sp = 8'h0; bus.status = 8'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
    #1;
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_rw", 64'(bus.rw), 64'(1));
    chk("reset_addr", 64'(bus.address), 64'(0));
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    // basic IRQ
    n0 = llog.size(); w0 = wlog.size();
    start_irq(16'h1234, 8'hFD, 8'hC3);
    wait_busy(ok);
    chk("irq_start", 64'(ok), 64'(1));
    bus.boundary = 0; bus.irq = 0;
    wait_load(n0, ok);
    chk("irq_done", 64'(ok), 64'(1));
    chk("irq_nwrites", 64'(wlog.size() - w0), 64'(3));
    chk("irq_w0", 64'(wlog[w0]), 64'(24'h01FD12));
    chk("irq_w1", 64'(wlog[w0 + 1]), 64'(24'h01FC34));
    chk("irq_w2", 64'(wlog[w0 + 2]), 64'(24'h01FBE3));
    chk("irq_pc", 64'(llog[n0]), 64'(16'h8000));
    repeat (2) @(negedge clk);
    chk("irq_idle", 64'(bus.busy), 64'(0));

    // masked IRQ
    bus.irq = 1; bus.i_flag = 1; bus.boundary = 1;
    repeat (20) begin
      @(negedge clk);
      chk("mask_pending", 64'(bus.int_pending), 64'(0));
      chk("mask_busy", 64'(bus.busy), 64'(0));
    end
    bus.irq = 0; bus.i_flag = 0; bus.boundary = 0;

    // NMI and IRQ arrive together; NMI wins
    @(negedge clk);
    n0 = llog.size();
    bus.nmi = 1; bus.irq = 1;
    @(negedge clk);
    bus.boundary = 1;
    wait_busy(ok);
    chk("nmi_start", 64'(ok), 64'(1));
    bus.boundary = 0; bus.irq = 0; bus.nmi = 0;
    wait_load(n0, ok);
    chk("nmi_done", 64'(ok), 64'(1));
    chk("nmi_pc", 64'(llog[n0]), 64'(16'h9000));
    repeat (2) @(negedge clk);
    chk("nmi_latch_clear", 64'(bus.int_pending), 64'(0));

    // NMI during PUSH_PCL of an IRQ stays pending
    n0 = llog.size();
    start_irq(16'h1234, 8'hFD, 8'hC3);
    wait_busy(ok);
    bus.boundary = 0; bus.irq = 0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus.address == 16'h01FC && !bus.rw;
    end
    chk("pend_pcl_seen", 64'(ok), 64'(1));
    bus.nmi = 1;
    @(negedge clk);
    bus.nmi = 0;
    wait_load(n0, ok);
    chk("pend_irq_pc", 64'(llog[n0]), 64'(16'h8000));
    chk("pend_nmi_pending", 64'(bus.int_pending), 64'(1));
    n0 = llog.size();
    bus.boundary = 1;
    wait_load(n0, ok);
    chk("pend_nmi_done", 64'(ok), 64'(1));
    chk("pend_nmi_pc", 64'(llog[n0]), 64'(16'h9000));
    bus.boundary = 0;
    repeat (2) @(negedge clk);

    // stack wrap with clk_enable toggling
    n0 = llog.size(); w0 = wlog.size(); ens = 0;
    start_irq(16'hABCD, 8'h01, 8'h00);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy) begin bus.boundary = 0; bus.irq = 0; end
      ok = llog.size() > n0 && !bus.busy;
      bus.clk_enable = ~bus.clk_enable;
      if (bus.busy && bus.clk_enable) ens++;
    end
    bus.clk_enable = 1;
    chk("wrap_done", 64'(ok), 64'(1));
    chk("wrap_cycles", 64'(ens), 64'(6));
    chk("wrap_w0", 64'(wlog[w0]), 64'(24'h0101AB));
    chk("wrap_w1", 64'(wlog[w0 + 1]), 64'(24'h0100CD));
    chk("wrap_w2", 64'(wlog[w0 + 2]), 64'(24'h01FF20));
    chk("wrap_nwrites", 64'(wlog.size() - w0), 64'(3));

    // reset in VEC_LO
    start_irq(16'h1234, 8'hFD, 8'hC3);
    wait_busy(ok);
    bus.boundary = 0; bus.irq = 0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus.address == 16'hFFFE && bus.rw;
    end
    chk("rst_veclo_seen", 64'(ok), 64'(1));
    n0 = llog.size();
    bus.nmi = 1;
    #2 rst = 1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_rw", 64'(bus.rw), 64'(1));
    chk("rst_addr", 64'(bus.address), 64'(0));
    @(negedge clk);
    rst = 0;
    bus.boundary = 1;
    repeat (10) begin
      @(negedge clk);
      chk("rst_nmi_ignored", 64'(bus.busy), 64'(0));
    end
    chk("rst_noload", 64'(llog.size() - n0), 64'(0));
    bus.nmi = 0; bus.boundary = 0;

    // random traffic
    for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
    repeat (800) begin
      @(negedge clk);
      rst = $urandom_range(0, 199) == 0;
      bus.clk_enable = $urandom_range(0, 3) != 0;
      bus.irq = $urandom_range(0, 3) == 0;
      bus.nmi = $urandom_range(0, 4) == 0;
      bus.i_flag = $urandom_range(0, 1) == 1;
      bus.boundary = $urandom_range(0, 1) == 1;
      bus.pc = 16'($urandom);
      bus.sp = 8'($urandom);
      bus.status = 8'($urandom);
    end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
